// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, frame state encoding and the arrow-key
// scancodes used by the downstream decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [15:0] KEY_UP    = 16'hE075;
  localparam logic [15:0] KEY_DOWN  = 16'hE072;
  localparam logic [15:0] KEY_LEFT  = 16'hE06B;
  localparam logic [15:0] KEY_RIGHT = 16'hE074;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // True when the 8 data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Pad lines into the receiver and the scancode/event outputs it produces.
interface ps2_scancode_rx_if;

  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] scancode;
  logic        evt_valid;
  logic [15:0] evt_code;
  logic        evt_break;
  logic        frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output scancode, evt_valid, evt_code, evt_break, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scancode, evt_valid, evt_code, evt_break, frame_err
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and frame reception: synchronizers, clock filter,
// falling-edge detect, start/data/parity/stop FSM and mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_s, dat_s;
  logic          filt;
  logic [FW-1:0] flt_cnt;
  logic          fall, bit_smp;

  frame_state_t  state, state_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic          par_ok, par_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          done_nxt, err_nxt;

  // Sync both lines; filtered clock flips only after FILTER_LEN differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      filt    <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
      bit_smp <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      fall  <= 1'b0;
      if (clk_s[1] == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= clk_s[1];
        flt_cnt <= '0;
        fall    <= filt;
        bit_smp <= dat_s[1];
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      bit_cnt   <= bit_nxt;
      par_ok    <= par_nxt;
      to_cnt    <= to_nxt;
      byte_done <= done_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_nxt   = bit_cnt;
    par_nxt   = par_ok;
    to_nxt    = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (state != ST_IDLE && !fall) to_nxt = to_cnt + TW'(1);

    case (state)
      ST_IDLE: begin
        if (fall && !bit_smp) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_nxt = {bit_smp, shift[7:1]};
          bit_nxt   = bit_cnt + 3'(1);
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_nxt   = odd_parity_ok({bit_smp, shift});
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (bit_smp && par_ok) done_nxt = 1'b1;
          else                   err_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Keyboard stopped clocking mid-frame: abandon the partial byte.
    if (state != ST_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      err_nxt   = 1'b1;
      state_nxt = ST_IDLE;
      to_nxt    = '0;
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: merges E0/F0 prefixes into 16-bit make/break events
// and holds the currently pressed key for the arrow-key decoder.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input logic               clk,
  input logic               reset,
  ps2_scancode_rx_if.master bus
);

  logic        byte_done, rx_err;
  logic [7:0]  rx_byte;
  logic        ext, brk;
  logic [15:0] code_c;
  logic [15:0] scancode_q, evt_code_q;
  logic        evt_valid_q, evt_break_q, frame_err_q;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .frame_err (rx_err)
  );

  assign code_c = {ext ? PS2_EXT : 8'h00, rx_byte};

  // Prefix tracking; a break only releases the key that is actually held.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      scancode_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_break_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      evt_valid_q <= 1'b0;
      frame_err_q <= rx_err;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_done) begin
        if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          evt_valid_q <= 1'b1;
          evt_code_q  <= code_c;
          evt_break_q <= brk;
          ext         <= 1'b0;
          brk         <= 1'b0;
          if (!brk)                      scancode_q <= code_c;
          else if (scancode_q == code_c) scancode_q <= '0;
        end
      end
    end
  end

  assign bus.scancode  = scancode_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_break = evt_break_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-banged PS/2 frames with hand-computed
// expected scancodes, events and error pulses.
module tb_ps2_scancode_rx;

  localparam int unsigned HALF = 20;

  logic clk;
  logic reset;
  int   nvec, nerr;
  int   evt_cnt, err_cnt;
  logic [15:0] last_code;
  logic        last_brk;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event/error recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.evt_valid) begin
        evt_cnt++;
        last_code = bus.evt_code;
        last_brk  = bus.evt_break;
      end
      if (bus.frame_err) err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of a frame: start, 8 data LSB-first, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    repeat (2 * HALF) @(negedge clk);
    bus.ps2_data = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic clr();
    evt_cnt   = 0;
    err_cnt   = 0;
    last_code = 16'hDEAD;
    last_brk  = 1'bx;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    clr();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_scancode",  32'(bus.scancode),  32'h0);
    chk("rst_evt_valid", 32'(bus.evt_valid), 32'h0);
    chk("rst_evt_code",  32'(bus.evt_code),  32'h0);
    chk("rst_evt_break", 32'(bus.evt_break), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: extended make for left arrow
    clr();
    tx(8'hE0); tx(8'h6B);
    chk("t1_evt_cnt", 32'(evt_cnt), 32'd1);
    chk("t1_code",    32'(last_code), 32'hE06B);
    chk("t1_brk",     32'(last_brk), 32'h0);
    chk("t1_scan",    32'(bus.scancode), 32'hE06B);
    repeat (200) @(negedge clk);
    chk("t1_held",    32'(bus.scancode), 32'hE06B);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 2: release of the held key
    clr();
    tx(8'hE0); tx(8'hF0); tx(8'h6B);
    chk("t2_evt_cnt", 32'(evt_cnt), 32'd1);
    chk("t2_code",    32'(last_code), 32'hE06B);
    chk("t2_brk",     32'(last_brk), 32'h1);
    chk("t2_scan",    32'(bus.scancode), 32'h0);

    // 3: release of a key other than the held one
    clr();
    tx(8'hE0); tx(8'h72);
    chk("t3_scan_make", 32'(bus.scancode), 32'hE072);
    tx(8'hE0); tx(8'hF0); tx(8'h74);
    chk("t3_evt_cnt", 32'(evt_cnt), 32'd2);
    chk("t3_code",    32'(last_code), 32'hE074);
    chk("t3_brk",     32'(last_brk), 32'h1);
    chk("t3_scan",    32'(bus.scancode), 32'hE072);

    // 4: bad parity is dropped with one error
    clr();
    send_frame(8'h6B, 1'b1, 11);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4_evt_cnt", 32'(evt_cnt), 32'd0);
    chk("t4_scan_kept", 32'(bus.scancode), 32'hE072);
    tx(8'hE0); tx(8'h75);
    chk("t4_code", 32'(last_code), 32'hE075);
    chk("t4_scan", 32'(bus.scancode), 32'hE075);

    // 5: clock stalls after 4 data bits
    clr();
    send_frame(8'h1C, 1'b0, 5);
    repeat (19000) @(negedge clk);
    chk("t5_no_early_err", 32'(err_cnt), 32'd0);
    repeat (2000) @(negedge clk);
    chk("t5_err_cnt", 32'(err_cnt), 32'd1);
    chk("t5_evt_none", 32'(evt_cnt), 32'd0);
    tx(8'h1C);
    chk("t5_code", 32'(last_code), 32'h001C);
    chk("t5_scan", 32'(bus.scancode), 32'h001C);
    chk("t5_err_after", 32'(err_cnt), 32'd1);

    // 6: reset mid-frame with a pending E0 prefix
    tx(8'hE0); tx(8'h6B);
    chk("t6_scan_pre", 32'(bus.scancode), 32'hE06B);
    tx(8'hE0);
    send_frame(8'h6B, 1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_scan", 32'(bus.scancode),  32'h0);
    chk("t6_rst_evt",  32'(bus.evt_valid), 32'h0);
    chk("t6_rst_code", 32'(bus.evt_code),  32'h0);
    chk("t6_rst_err",  32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    clr();
    tx(8'h6B);
    chk("t6_evt_cnt", 32'(evt_cnt), 32'd1);
    chk("t6_code",    32'(last_code), 32'h006B);
    chk("t6_scan",    32'(bus.scancode), 32'h006B);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);

    // 7: ps2_clk glitches one sample shorter than the filter
    clr();
    bus.ps2_data = 1'b0;
    for (int g = 0; g < 6; g++) begin
      bus.ps2_clk = 1'b0;
      repeat (7) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
    end
    bus.ps2_data = 1'b1;
    repeat (50) @(negedge clk);
    chk("t7_err_cnt", 32'(err_cnt), 32'd0);
    chk("t7_evt_cnt", 32'(evt_cnt), 32'd0);
    tx(8'h29);
    chk("t7_code", 32'(last_code), 32'h0029);
    chk("t7_scan", 32'(bus.scancode), 32'h0029);
    chk("t7_err_after", 32'(err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
